// File: rtl/led_row_scanner.sv
// led_row_scanner
//   Drives a row-multiplexed LED matrix from a frame bitmap supplied by game
//   logic. A new frame is copied into a shadow buffer only in the single LOAD
//   cycle between scan frames, so the picture never tears mid-frame. Each row
//   is preceded by an all-off blanking gap to suppress ghosting.
//
//   Frame sequence: LOAD (1 cycle), then for every row a BLANK phase of
//   BLANK cycles followed by a DRIVE phase of DWELL cycles.
//   Frame period = ROWS*(BLANK+DWELL)+1 cycles.
//
//   All matrix outputs are registered from the next-state decode, so they
//   change on the same edge as the state with no extra lag cycle.

module led_row_scanner #(
    parameter int ROWS  = 16,    // number of matrix rows (>= 2)
    parameter int COLS  = 16,    // number of matrix columns (>= 1)
    parameter int DWELL = 2048,  // cycles each row is driven (>= 1)
    parameter int BLANK = 16     // all-off cycles before each row (>= 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ROWS*COLS-1:0] frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ack,
    output logic                 frame_start,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data
);

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    // A phase of one cycle would give $clog2 of 0; keep at least one bit.
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int ROW_W   = $clog2(ROWS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State, counters, shadow buffer and registered outputs
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [ROW_W-1:0]       r_row;
    logic [CNT_W-1:0]       r_cnt;
    logic [ROWS*COLS-1:0]   r_shadow;
    logic [ROWS-1:0]        r_row_sel;
    logic [COLS-1:0]        r_col_data;
    logic                   r_frame_ack;
    logic                   r_frame_start;

    state_t                 w_state_nxt;
    logic [ROW_W-1:0]       w_row_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_capture;
    logic [ROWS-1:0]        w_row_sel_nxt;
    logic [COLS-1:0]        w_col_data_nxt;
    logic [COLS-1:0]        w_row_data [ROWS];

    // Slice the shadow buffer into per-row column words.
    for (genvar g = 0; g < ROWS; g++) begin : g_row_data
        assign w_row_data[g] = r_shadow[g*COLS +: COLS];
    end

    // A frame is taken only when game logic offers one during LOAD.
    assign w_capture = (r_state == S_LOAD) && frame_valid;

    // Next-state, next-row and cycle-counter decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt + CNT_W'(1);

        unique case (r_state)
            S_LOAD: begin
                w_state_nxt = S_BLANK;
                w_row_nxt   = '0;
                w_cnt_nxt   = '0;
            end
            S_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRIVE: begin
                if (r_cnt == DWELL_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_row == ROW_LAST) begin
                        w_state_nxt = S_LOAD;
                        w_row_nxt   = '0;
                    end else begin
                        w_state_nxt = S_BLANK;
                        w_row_nxt   = r_row + ROW_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
                w_row_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Matrix drive decoded from the next state. DRIVE is never entered
    // directly from LOAD, so the shadow buffer is stable whenever a row
    // is about to be driven and the current copy can be used.
    always_comb begin
        w_row_sel_nxt  = '0;
        w_col_data_nxt = '0;
        if (w_state_nxt == S_DRIVE) begin
            w_row_sel_nxt  = ROWS'(1) << w_row_nxt;
            w_col_data_nxt = w_row_data[w_row_nxt];
        end
    end

    // Scan state register; reset parks the FSM in LOAD at row 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_LOAD;
            r_row   <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop updates from the values present before the edge.
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow buffer: loaded only on the edge that leaves a capturing LOAD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the shadow is a flop array rather than a RAM, so it can
            // be cleared here; the first frame after reset is dark.
            r_shadow <= '0;
        end else if (w_capture) begin
            r_shadow <= frame_in;
        end
    end

    // Registered matrix outputs and the frame-boundary pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_row_sel     <= '0;
            r_col_data    <= '0;
            r_frame_ack   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_row_sel     <= w_row_sel_nxt;
            r_col_data    <= w_col_data_nxt;
            r_frame_ack   <= w_capture;
            r_frame_start <= (r_state == S_LOAD);
        end
    end

    assign row_sel     = r_row_sel;
    assign col_data    = r_col_data;
    assign frame_ack   = r_frame_ack;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_led_row_scanner.sv
// tb_led_row_scanner
//   Directed bench for led_row_scanner with ROWS=4, COLS=4, DWELL=3, BLANK=2
//   (21-cycle frame). Expected outputs come from the frame timeline:
//   position 0 is the LOAD cycle, then each row occupies 5 cycles
//   (2 blank, 3 driven). A background monitor checks the per-cycle
//   invariants and the frame_start spacing.

module tb_led_row_scanner;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DWELL  = 3;
    localparam int BLANK  = 2;
    localparam int PERIOD = ROWS * (BLANK + DWELL) + 1;  // 21

    logic                 CLK;
    logic                 RST;
    logic [ROWS*COLS-1:0] frame_in;
    logic                 frame_valid;
    logic                 frame_ack;
    logic                 frame_start;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_data;

    int n_checks = 0;
    int n_errors = 0;

    led_row_scanner #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_start (frame_start),
        .row_sel     (row_sel),
        .col_data    (col_data)
    );

    // 10-unit clock: rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Packs {frame_ack, frame_start, row_sel, col_data} into one word.
    function automatic logic [31:0] pack(input logic fa, input logic fs,
                                         input logic [3:0] rs, input logic [3:0] cd);
        return {22'd0, fa, fs, rs, cd};
    endfunction

    // Walk one scan frame starting at its LOAD cycle, sampling on falling
    // edges. At position chg_p the inputs are changed (pulse: valid drops
    // again one cycle later). Stops early after sampling position stop_p.
    task automatic run_frame(input string name, input logic [15:0] exp_img,
                             input logic exp_ack, input int chg_p,
                             input logic [15:0] chg_in, input logic chg_valid,
                             input logic pulse, input int stop_p);
        logic [3:0] exp_rs;
        logic [3:0] exp_cd;
        int q, r;
        for (int p = 0; p < PERIOD; p++) begin
            @(negedge CLK);
            exp_rs = 4'b0000;
            exp_cd = 4'b0000;
            if (p > 0) begin
                q = p - 1;
                r = q / 5;
                if ((q % 5) >= 2) begin
                    exp_rs = 4'b0001 << r;
                    exp_cd = exp_img[r*4 +: 4];
                end
            end
            check($sformatf("%s p%0d", name, p),
                  pack(frame_ack, frame_start, row_sel, col_data),
                  pack(exp_ack && (p == 1), p == 1, exp_rs, exp_cd));
            if (p == stop_p) return;
            if (pulse && p == chg_p + 1) frame_valid = 1'b0;
            if (p == chg_p) begin
                frame_in    = chg_in;
                frame_valid = chg_valid;
            end
        end
    endtask

    // Per-cycle invariants and frame_start spacing.
    int  mon_cyc  = 0;
    bit  mon_seen = 0;
    always @(negedge CLK) begin
        if (RST) begin
            mon_seen = 0;
            mon_cyc  = 0;
        end else begin
            check("onehot", {31'd0, $countones(row_sel) <= 1}, 32'd1);
            check("blank_cols", {31'd0, (row_sel == 4'b0000) && (col_data != 4'b0000)}, 32'd0);
            mon_cyc++;
            if (frame_start) begin
                if (mon_seen) check("fs_spacing", mon_cyc, PERIOD);
                mon_seen = 1;
                mon_cyc  = 0;
            end else if (mon_seen && mon_cyc > PERIOD) begin
                check("fs_missing", mon_cyc, PERIOD);
                mon_seen = 0;
            end
        end
    end

    initial begin
        RST         = 1'b0;
        frame_in    = '0;
        frame_valid = 1'b0;

        // 1. Reset: outputs clear without a clock edge and stay clear.
        #1 RST = 1'b1;
        #2 check("reset_async", pack(frame_ack, frame_start, row_sel, col_data), 32'd0);
        repeat (3) @(posedge CLK);
        #1 check("reset_held", pack(frame_ack, frame_start, row_sel, col_data), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Frame 1: nothing offered, dark frame, no ack.
        run_frame("f1_idle", 16'h0000, 1'b0, -1, 16'h0000, 1'b0, 1'b0, -1);

        // 2/3. Capture A5C3; during row-1 DRIVE switch to FFFF with valid held.
        frame_in    = 16'hA5C3;
        frame_valid = 1'b1;
        run_frame("f2_cap", 16'hA5C3, 1'b1, 8, 16'hFFFF, 1'b1, 1'b0, -1);

        // Next frame shows FFFF; valid dropped after the LOAD cycle.
        run_frame("f3_new", 16'hFFFF, 1'b1, 1, 16'h1234, 1'b0, 1'b0, -1);

        // 4. One-cycle valid pulse inside the row-1 BLANK: ignored.
        run_frame("f4_miss", 16'hFFFF, 1'b0, 6, 16'h1234, 1'b1, 1'b1, -1);
        run_frame("f5_keep", 16'hFFFF, 1'b0, -1, 16'h0000, 1'b0, 1'b0, -1);

        // 5. Async reset between edges during row-2 DRIVE.
        run_frame("f6_pre", 16'hFFFF, 1'b0, -1, 16'h0000, 1'b0, 1'b0, 13);
        #2 RST = 1'b1;
        #1 check("rst_mid_drive", pack(frame_ack, frame_start, row_sel, col_data), 32'd0);
        @(posedge CLK);
        #1 check("rst_mid_held", pack(frame_ack, frame_start, row_sel, col_data), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // 6. Three dark frames after reset; monitor checks spacing/invariants.
        run_frame("f7_post", 16'h0000, 1'b0, -1, 16'h0000, 1'b0, 1'b0, -1);
        run_frame("f8_post", 16'h0000, 1'b0, -1, 16'h0000, 1'b0, 1'b0, -1);
        run_frame("f9_post", 16'h0000, 1'b0, -1, 16'h0000, 1'b0, 1'b0, -1);

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
